// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : Request/result bundle for the bit-serial adder. The master
//               side issues start with operands; the slave side returns
//               busy/done and the registered sum. The ovf signal exists only
//               when SERIAL_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] soma;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, soma, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, soma, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, soma, cout);
    modport slave  (input start, a, b, cin, output busy, done, soma, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder built from one full-adder cell and
//               a carry flop. Operands are shifted out LSB first, one bit per
//               clock; the sum is assembled in a result register and
//               published to soma/cout only on completion.
//               Optional macro SERIAL_ADDER_OVF_EN adds the signed overflow
//               output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    serial_adder_if.slave   bus
);

    localparam int            CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] soma_q, soma_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic w_fa_sum;
    logic w_fa_carry;
    logic w_last;

    // The single full-adder cell: operand LSBs plus the stored carry.
    assign w_fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign w_fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign w_last     = (cnt_q == c_LAST);

    // State register; reset aborts any addition in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: shifters, carry, counter, result and published sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            soma_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            soma_q  <= soma_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and datapath control. A capture in IDLE or DONE overrides
    // the default transition, which is what makes back-to-back work.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        soma_d  = soma_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                res_d   = {w_fa_sum, res_q[WIDTH-1:1]};
                carry_d = w_fa_carry;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (w_last) begin
                    // Publish on the last bit; the MSB sum bit goes straight
                    // into soma rather than via the result register.
                    soma_d  = {w_fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = w_fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB position.
                    ovf_d   = carry_q ^ w_fa_carry;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q != S_RUN) && bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
            res_d   = '0;
            state_d = S_RUN;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.soma = soma_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder at WIDTH=8.
//               Inputs change on the falling edge; outputs are sampled on the
//               falling edge or shortly after an asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] bb_a   [4] = '{8'h12, 8'hF0, 8'hAA, 8'h80};
    logic [7:0] bb_b   [4] = '{8'h34, 8'h20, 8'h55, 8'h7F};
    logic       bb_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] bb_s   [4] = '{8'h46, 8'h11, 8'hFF, 8'h00};
    logic       bb_co  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one start and wait (bounded) for done; lat is the falling-edge
    // index after the start edge at which done was seen, -1 on timeout.
    task automatic run_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                           output logic [7:0] s, output logic c, output logic o,
                           output int lat, output int busy_n);
        @(negedge clk);
        bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.cin = ic;
        lat = -1; busy_n = 0; s = '0; c = 1'b0; o = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus.start = 1'b0; bus.a = 8'hA5; bus.b = 8'h5A; bus.cin = 1'b1;
            end
            if (bus.done) begin
                lat = n; s = bus.soma; c = bus.cout; o = get_ovf();
                break;
            end
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.soma !== 8'h00) begin errors++; $display("FAIL reset_soma: got %h expected 00", bus.soma); end
        checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
`ifdef SERIAL_ADDER_OVF_EN
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] s; logic c; logic o; int lat; int bn;
        run_add(8'h0F, 8'h01, 1'b0, s, c, o, lat, bn);
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        checks++; if (bn !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bn); end
        checks++; if (s !== 8'h10) begin errors++; $display("FAIL basic_soma: got %h expected 10", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", c); end
        @(negedge clk);
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL basic_idle_after: got %b expected 00", {bus.busy, bus.done}); end
        checks++; if (bus.soma !== 8'h10) begin errors++; $display("FAIL basic_soma_held: got %h expected 10", bus.soma); end
    endtask

    task automatic test_carry();
        logic [7:0] s; logic c; logic o; int lat; int bn;
        run_add(8'hFF, 8'h01, 1'b0, s, c, o, lat, bn);
        checks++; if ({c, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got %h expected 100", {c, s}); end
        run_add(8'hFF, 8'hFF, 1'b1, s, c, o, lat, bn);
        checks++; if ({c, s} !== 9'h1FF) begin errors++; $display("FAIL carry_ff_ff_cin: got %h expected 1ff", {c, s}); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL carry_latency: got %0d expected 8", lat); end
    endtask

    task automatic test_ovf();
`ifdef SERIAL_ADDER_OVF_EN
        logic [7:0] s; logic c; logic o; int lat; int bn;
        run_add(8'h7F, 8'h01, 1'b0, s, c, o, lat, bn);
        checks++; if ({o, c, s} !== 10'h280) begin errors++; $display("FAIL ovf_7f_01: got ovf=%b cout=%b soma=%h expected ovf=1 cout=0 soma=80", o, c, s); end
        run_add(8'h80, 8'h80, 1'b0, s, c, o, lat, bn);
        checks++; if ({o, c, s} !== 10'h300) begin errors++; $display("FAIL ovf_80_80: got ovf=%b cout=%b soma=%h expected ovf=1 cout=1 soma=00", o, c, s); end
        run_add(8'h05, 8'h03, 1'b0, s, c, o, lat, bn);
        checks++; if ({o, c, s} !== 10'h008) begin errors++; $display("FAIL ovf_05_03: got ovf=%b cout=%b soma=%h expected ovf=0 cout=0 soma=08", o, c, s); end
`endif
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [7:0] s; logic c;
        lat = -1; s = '0; c = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) bus.start = 1'b0;
            if (n == 3) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; end
            if (n == 4) bus.start = 1'b0;
            if (bus.done) begin lat = n; s = bus.soma; c = bus.cout; break; end
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_latency: got %0d expected 8", lat); end
        checks++; if ({c, s} !== 9'h030) begin errors++; $display("FAIL ignore_result: got %h expected 030", {c, s}); end
        @(negedge clk);
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL ignore_idle_after: got %b expected 00", {bus.busy, bus.done}); end
    endtask

    task automatic test_back_to_back();
        int cyc; int last; int idx; int overlap;
        cyc = 0; last = 0; idx = 0; overlap = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = bb_a[0]; bus.b = bb_b[0]; bus.cin = bb_c[0];
        for (int k = 0; k < 60 && idx < 4; k++) begin
            @(negedge clk);
            cyc++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                checks++; if (bus.soma !== bb_s[idx]) begin errors++; $display("FAIL b2b_soma[%0d]: got %h expected %h", idx, bus.soma, bb_s[idx]); end
                checks++; if (bus.cout !== bb_co[idx]) begin errors++; $display("FAIL b2b_cout[%0d]: got %b expected %b", idx, bus.cout, bb_co[idx]); end
                checks++; if ((cyc - last) !== 9) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d expected 9", idx, cyc - last); end
                last = cyc;
                idx++;
                if (idx < 4) begin
                    bus.a = bb_a[idx]; bus.b = bb_b[idx]; bus.cin = bb_c[idx];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        checks++; if (idx !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", idx); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_busy_done_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] s; logic c; logic o; int lat; int bn; int done_seen;
        run_add(8'h90, 8'h90, 1'b0, s, c, o, lat, bn);
        checks++; if ({c, s} !== 9'h120) begin errors++; $display("FAIL pre_reset_result: got %h expected 120", {c, s}); end
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 0) bus.start = 1'b0;
        end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before_reset: got %b expected 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL midrun_reset_flags: got %b expected 00", {bus.busy, bus.done}); end
        checks++; if ({bus.cout, bus.soma} !== 9'h000) begin errors++; $display("FAIL midrun_reset_result: got %h expected 000", {bus.cout, bus.soma}); end
`ifdef SERIAL_ADDER_OVF_EN
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL midrun_reset_ovf: got %b expected 0", bus.ovf); end
`endif
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d expected 0", done_seen); end
        run_add(8'h01, 8'h02, 1'b0, s, c, o, lat, bn);
        checks++; if ({c, s} !== 9'h003) begin errors++; $display("FAIL after_reset_result: got %h expected 003", {c, s}); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL after_reset_latency: got %0d expected 8", lat); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_carry();
        test_ovf();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
